// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Mini SRC control unit; Moore FSM that fetches, then runs an
// opcode-specific execute sequence and drives every CPU control strobe.
module control_sequencer #(
  parameter int OPW = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        stop,
  output logic        run,
  output logic        CON_RESET,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zlowout,
  output logic        INout,
  output logic        Cout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Rin,
  output logic        OUT_Portin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rout,
  output logic        BAout,
  output logic        IncPC,
  output logic        Read,
  output logic        read_mem,
  output logic        write_mem,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR
);
  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;
  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_IN   = 5'b10110;
  localparam logic [OPW-1:0] OP_OUT  = 5'b10111;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;
  state_t r_state, w_next;
  logic [OPW-1:0] w_op;
  logic w_alu, w_imm, w_mem, w_ld, w_st, w_in, w_out, w_unused;
  state_t w_last;
  assign w_op     = IR[31:32-OPW];
  assign w_unused = ^IR[31-OPW:0];
  assign w_ld     = w_op == OP_LD;
  assign w_st     = w_op == OP_ST;
  assign w_in     = w_op == OP_IN;
  assign w_out    = w_op == OP_OUT;
  assign w_alu    = w_op == OP_ADD || w_op == OP_SUB || w_op == OP_AND || w_op == OP_OR;
  assign w_imm    = w_op == OP_ADDI || w_op == OP_LDI;
  assign w_mem    = w_ld || w_st;
  // stop only takes effect at an instruction boundary
  assign w_last   = stop ? S_HALT : S_T0;
  always_ff @(posedge clk)
    r_state <= !reset ? S_RST : w_next;
  always_comb begin
    w_next = S_RST;
    case (r_state)
      S_RST:  w_next = S_T0;
      S_T0:   w_next = S_T1;
      S_T1:   w_next = S_T2;
      S_T2:   w_next = S_T3;
      S_T3:   w_next = (w_alu || w_imm || w_mem) ? S_T4 : (w_op == OP_HALT) ? S_HALT : w_last;
      S_T4:   w_next = S_T5;
      S_T5:   w_next = w_mem ? S_T6 : w_last;
      S_T6:   w_next = S_T7;
      S_T7:   w_next = w_last;
      S_HALT: w_next = S_HALT;
      default: w_next = S_RST;
    endcase
  end
  always_comb begin
    run = r_state != S_HALT;
    {CON_RESET, PCout, MDRout, Zlowout, INout, Cout} = '0;
    {PCin, IRin, MARin, MDRin, Yin, Zin, Rin, OUT_Portin} = '0;
    {Gra, Grb, Grc, Rout, BAout, IncPC, Read, read_mem, write_mem} = '0;
    {ADD, SUB, AND, OR} = '0;
    case (r_state)
      S_RST: CON_RESET = 1'b1;
      S_T0: {PCout, MARin, IncPC, PCin} = '1;
      S_T1: {Read, read_mem, MDRin} = '1;
      S_T2: {MDRout, IRin} = '1;
      S_T3: begin
        Grb        = w_alu || w_imm || w_mem;
        Yin        = w_alu || w_imm || w_mem;
        BAout      = w_op == OP_LDI || w_mem;
        Rout       = w_alu || w_op == OP_ADDI || w_out;
        INout      = w_in;
        Rin        = w_in;
        Gra        = w_in || w_out;
        OUT_Portin = w_out;
      end
      S_T4: begin
        Grc  = w_alu;
        Rout = w_alu;
        Cout = w_imm || w_mem;
        Zin  = w_alu || w_imm || w_mem;
        ADD  = w_op == OP_ADD || w_imm || w_mem;
        SUB  = w_op == OP_SUB;
        AND  = w_op == OP_AND;
        OR   = w_op == OP_OR;
      end
      S_T5: begin
        Zlowout = w_alu || w_imm || w_mem;
        Gra     = w_alu || w_imm;
        Rin     = w_alu || w_imm;
        MARin   = w_mem;
      end
      S_T6: begin
        Read     = w_ld;
        read_mem = w_ld;
        MDRin    = w_mem;
        Gra      = w_st;
        Rout     = w_st;
      end
      S_T7: begin
        MDRout    = w_ld;
        Gra       = w_ld;
        Rin       = w_ld;
        write_mem = w_st;
      end
      default: ;
    endcase
  end
endmodule
